// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths and FSM state type for the dcache tag controller
package dcache_pkg;

  localparam int TAG_W = 25;
  localparam int IDX_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } tag_ctrl_state_t;

endpackage

// File: rtl/dcache_tag_parity.sv
// rtl/dcache_tag_parity.sv - even parity generate for tag writes and check for tag reads
module dcache_tag_parity #(
  parameter int W = 25
) (
  input  logic [W-2:0] gen_data,
  input  logic [W-1:0] chk_data,
  output logic         par,
  output logic         err
);

  // Parity bit makes the stored word XOR to zero; any odd flip shows up as err.
  assign par = ^gen_data;
  assign err = ^chk_data;

endmodule

// File: rtl/dcache_tag_ctrl.sv
// rtl/dcache_tag_ctrl.sv - 1RW tag SRAM initiator with init/flush sweep; optional TAG_PARITY_EN
module dcache_tag_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_W = TAG_W,
  parameter int ADDR_W = IDX_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_idx,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] dout0
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  tag_ctrl_state_t   state;
  tag_ctrl_state_t   state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              rd_pend;
  logic [DATA_W-1:0] wdata_m;
  logic              rd_perr;

`ifdef TAG_PARITY_EN
  logic par_bit;

  dcache_tag_parity #(
    .W (DATA_W)
  ) u_parity (
    .gen_data (req_wdata[DATA_W-2:0]),
    .chk_data (dout0),
    .par      (par_bit),
    .err      (rd_perr)
  );

  assign wdata_m = {par_bit, req_wdata[DATA_W-2:0]};
`else
  assign wdata_m = req_wdata;
  assign rd_perr = 1'b0;
`endif

  assign init_done = (state == IDLE);

  // State and sweep counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and macro port drive; reset forces the port idle without waiting for an edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    csb0      = 1'b1;
    web0      = 1'b1;
    addr0     = '0;
    din0      = '0;
    if (!rst) begin
      case (state)
        INIT: begin
          csb0    = 1'b0;
          web0    = 1'b0;
          addr0   = cnt;
          cnt_nxt = cnt + ADDR_W'(1);
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        IDLE: begin
          req_ready = !flush_req;
          csb0      = !(req_valid && req_ready);
          web0      = !req_we;
          addr0     = req_idx;
          din0      = wdata_m;
          if (flush_req) begin
            state_nxt = INIT;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  // Read response pipeline: the macro answers one cycle after sampling, so dout0 is captured one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_perr  <= 1'b0;
    end else begin
      rd_pend   <= req_valid && req_ready && !req_we;
      rsp_valid <= rd_pend;
      if (rd_pend) begin
        rsp_rdata <= dout0;
        rsp_perr  <= rd_perr;
      end
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb/tb_dcache_tag_ctrl.sv - bench for dcache_tag_ctrl with macro model and reference model; honours TAG_PARITY_EN
module tb_dcache_tag_ctrl;

  localparam int DW    = 25;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req;
  logic          init_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_idx;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_perr;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  int n_chk  = 0;
  int n_fail = 0;

  dcache_tag_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush_req (flush_req),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_idx   (req_idx),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_perr  (rsp_perr),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  always #5 clk = ~clk;

  // Tag SRAM macro: registers its port on posedge, read data appears after that edge.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) sram_mem[addr0] <= din0;
      else       dout0 <= sram_mem[addr0];
    end
  end

  // Reference model: array contents, remaining sweep writes, and a queue of due responses.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  int            sweep_left;
  int            edge_n;
  rsp_t          rq[$];

  typedef struct {
    bit            flush;
    bit            valid;
    bit            we;
    logic [AW-1:0] idx;
    logic [DW-1:0] wdata;
    bit            exp_ready;
    bit            exp_valid;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] w);
`ifdef TAG_PARITY_EN
    return {^w[DW-2:0], w[DW-2:0]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic drive(input bit f, input bit v, input bit w, input logic [AW-1:0] i, input logic [DW-1:0] d);
    flush_req = f;
    req_valid = v;
    req_we    = w;
    req_idx   = i;
    req_wdata = d;
  endtask

  task automatic model_check();
    logic er;
    logic acc;
    er  = !rst && sweep_left == 0 && !flush_req;
    acc = req_valid && er;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("init_done", 32'(init_done), 32'(!rst && sweep_left == 0));
    if (rst) begin
      chk("rst_csb0", 32'(csb0), 32'(1));
      chk("rst_web0", 32'(web0), 32'(1));
      chk("rst_addr0", 32'(addr0), 32'(0));
      chk("rst_din0", 32'(din0), 32'(0));
    end else if (sweep_left > 0) begin
      chk("sweep_csb0", 32'(csb0), 32'(0));
      chk("sweep_web0", 32'(web0), 32'(0));
      chk("sweep_addr0", 32'(addr0), 32'(DEPTH - sweep_left));
      chk("sweep_din0", 32'(din0), 32'(0));
    end else begin
      chk("idle_csb0", 32'(csb0), 32'(!acc));
      if (acc) begin
        chk("idle_web0", 32'(web0), 32'(!req_we));
        chk("idle_addr0", 32'(addr0), 32'(req_idx));
        if (req_we) chk("idle_din0", 32'(din0), 32'(stored(req_wdata)));
      end
    end
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(1));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(rq[0].data));
`ifdef TAG_PARITY_EN
      chk("rsp_perr", 32'(rsp_perr), 32'(^rq[0].data));
`else
      chk("rsp_perr", 32'(rsp_perr), 32'(0));
`endif
      void'(rq.pop_front());
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'(0));
    end
  endtask

  task automatic model_edge();
    edge_n++;
    if (rst) begin
      sweep_left = DEPTH;
      rq.delete();
      clear_ref();
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else if (flush_req) begin
      sweep_left = DEPTH;
      clear_ref();
    end else if (req_valid) begin
      if (req_we) ref_mem[req_idx] = stored(req_wdata);
      else        rq.push_back('{due: edge_n + 1, data: ref_mem[req_idx]});
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < n; i++) begin
      sample();
      step();
    end
  endtask

  initial begin
    int sweep_cnt;

    vecs[0]  = '{0, 1, 1, 4'd1, 25'h0123456, 1, 0, 25'h0};
    vecs[1]  = '{0, 1, 1, 4'd2, 25'h0FEDCBA, 1, 0, 25'h0};
    vecs[2]  = '{0, 1, 1, 4'd3, 25'h0ABCDEF, 1, 0, 25'h0};
    vecs[3]  = '{0, 1, 0, 4'd3, 25'h0,       1, 0, 25'h0};
    vecs[4]  = '{0, 1, 0, 4'd1, 25'h0,       1, 0, 25'h0};
    vecs[5]  = '{0, 1, 0, 4'd2, 25'h0,       1, 1, 25'h0ABCDEF};
    vecs[6]  = '{0, 1, 0, 4'd3, 25'h0,       1, 1, 25'h0123456};
    vecs[7]  = '{0, 0, 0, 4'd0, 25'h0,       1, 1, 25'h0FEDCBA};
    vecs[8]  = '{0, 0, 0, 4'd0, 25'h0,       1, 1, 25'h0ABCDEF};
    vecs[9]  = '{0, 0, 0, 4'd0, 25'h0,       1, 0, 25'h0};
    vecs[10] = '{1, 1, 1, 4'd3, 25'h1555555, 0, 0, 25'h0};

    rst = 1'b1;
    drive(0, 1, 1, 4'd5, '1);
    for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 25'($urandom);
    dout0 <= '0;
    clear_ref();
    sweep_left = DEPTH;
    edge_n     = 0;

    // Reset values, with a live request showing the port is forced idle.
    sample();
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'(0));
    chk("reset_rsp_perr", 32'(rsp_perr), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    step();
    sample();
    step();
    rst = 1'b0;

    // Power-on sweep length.
    drive(0, 0, 0, '0, '0);
    sweep_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      sample();
      if (!csb0 && !web0) sweep_cnt++;
      step();
    end
    chk("sweep_len", 32'(sweep_cnt), 32'(16));
    sample();
    chk("init_done_c17", 32'(init_done), 32'(1));
    step();

    // Table: writes, write-then-read, back-to-back reads, flush beating a write.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].flush, vecs[i].valid, vecs[i].we, vecs[i].idx, vecs[i].wdata);
      sample();
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(stored(vecs[i].exp_rdata)));
      step();
    end
    idle_cycles(DEPTH);

    // Idx 3 must read back zero after the flush sweep.
    drive(0, 1, 0, 4'd3, '0);
    sample();
    step();
    drive(0, 0, 0, '0, '0);
    sample();
    step();
    sample();
    chk("flush_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("flush_rsp_rdata", 32'(rsp_rdata), 32'(0));
    step();

    // Read accepted the cycle before a flush still responds.
    drive(0, 1, 1, 4'd2, 25'h055AA55);
    sample();
    step();
    drive(0, 1, 0, 4'd2, '0);
    sample();
    step();
    drive(1, 0, 0, '0, '0);
    sample();
    step();
    drive(0, 0, 0, '0, '0);
    sample();
    chk("pre_flush_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("pre_flush_rsp_rdata", 32'(rsp_rdata), 32'(stored(25'h055AA55)));
    step();
    idle_cycles(DEPTH);

    // Reset in the middle of a sweep.
    drive(1, 0, 0, '0, '0);
    sample();
    step();
    drive(0, 0, 0, '0, '0);
    for (int i = 0; i < 7; i++) begin
      sample();
      step();
    end
    chk("pre_rst_addr0", 32'(addr0), 32'(7));
    rst = 1'b1;
    sweep_left = DEPTH;
    rq.delete();
    clear_ref();
    #1;
    chk("async_rst_csb0", 32'(csb0), 32'(1));
    chk("async_rst_addr0", 32'(addr0), 32'(0));
    sample();
    step();
    sample();
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sample();
      if (i == 0) chk("restart_addr0", 32'(addr0), 32'(0));
      step();
    end

`ifdef TAG_PARITY_EN
    // Corrupt one stored bit and expect a parity error; a clean entry must not flag.
    drive(0, 1, 1, 4'd5, 25'h0123456);
    sample();
    step();
    idle_cycles(1);
    sram_mem[5] <= sram_mem[5] ^ 25'h8;
    ref_mem[5] = ref_mem[5] ^ 25'h8;
    drive(0, 1, 0, 4'd5, '0);
    sample();
    step();
    drive(0, 1, 0, 4'd4, '0);
    sample();
    step();
    drive(0, 0, 0, '0, '0);
    sample();
    chk("perr_flipped", 32'(rsp_perr), 32'(1));
    step();
    sample();
    chk("perr_clean", 32'(rsp_perr), 32'(0));
    step();
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, DEPTH - 1)), 25'($urandom));
      sample();
      step();
    end
    idle_cycles(4);
    chk("rsp_queue_drained", 32'(rq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
